// File: rtl/seq_alu_unit.sv
// Multi-cycle execute ALU: single-cycle ADD/SUB/logic/shift, shift-add MUL and an
// optional restoring DIV/REM sequencer (built only when SEQ_ALU_DIV_EN is defined).
// Word bit 0 of the codebase (the MSB) is index WIDTH-1 of every vector here.
//
//   state  | meaning
//   IDLE   | empty, ready for an operand bundle
//   MUL    | shift-add multiply, one partial product per clock
//   DIV    | restoring divide, one quotient bit per clock
//   DONE   | result presented on out_valid until out_ready
module seq_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_REM = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  state_t w_launch;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic             r_err;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_last_iter;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_c;
  logic             w_alu_err;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi_nxt;
  logic [WIDTH-1:0] w_mul_lo_nxt;

  assign in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign w_last_iter = (r_cnt == CNT_W'(1));

  assign r   = r_res;
  assign c   = r_c;
  assign err = r_err;
  assign n   = r_res[WIDTH-1];
  assign z   = (r_res == '0);

  assign w_is_mul = (op == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
  // Divide by zero never enters the sequencer; it falls to the illegal-op path.
  assign w_is_div = ((op == OP_DIV) || (op == OP_REM)) && (b != '0);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_launch = w_is_mul ? S_MUL : (w_is_div ? S_DIV : S_DONE);

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_sh   = b[SH_W-1:0];

  always_comb begin
    w_alu_r   = '0;
    w_alu_c   = 1'b0;
    w_alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_r = w_sum[WIDTH-1:0];
        w_alu_c = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_r = w_diff[WIDTH-1:0];
        w_alu_c = ~w_diff[WIDTH];
      end
      OP_AND: w_alu_r = a & b;
      OP_OR:  w_alu_r = a | b;
      OP_XOR: w_alu_r = a ^ b;
      OP_SHL: w_alu_r = a << w_sh;
      OP_SHR: w_alu_r = a >> w_sh;
      OP_SHA: w_alu_r = $signed(a) >>> w_sh;
      default: w_alu_err = 1'b1;
    endcase
  end

  // Right-shifting product: {r_hi, r_lo} starts as {0, multiplier}.
  assign w_mul_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi_nxt = w_mul_sum[WIDTH:1];
  assign w_mul_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic             r_rem_sel;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_rem_nxt;
  logic [WIDTH-1:0] w_div_quo_nxt;

  // r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in.
  assign w_div_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_div_trial   = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok      = ~w_div_trial[WIDTH];
  assign w_div_rem_nxt = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_quo_nxt = {r_lo[WIDTH-2:0], w_div_ok};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = w_launch;
      S_MUL:  if (w_last_iter) w_state_nxt = S_DONE;
`ifdef SEQ_ALU_DIV_EN
      S_DIV:  if (w_last_iter) w_state_nxt = S_DONE;
`else
      S_DIV:  w_state_nxt = S_IDLE;
`endif
      S_DONE: if (out_ready) w_state_nxt = in_valid ? w_launch : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers only change on a single-cycle accept or on the final iteration,
  // so they stay frozen while DONE waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_res  <= '0;
      r_c    <= 1'b0;
      r_err  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      r_rem_sel <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt  <= CNT_W'(WIDTH);
      r_hi   <= '0;
      r_lo   <= w_is_mul ? b : a;
      r_opnd <= w_is_mul ? a : b;
`ifdef SEQ_ALU_DIV_EN
      r_rem_sel <= (op == OP_REM);
`endif
      if (!w_is_mul && !w_is_div) begin
        r_res <= w_alu_r;
        r_c   <= w_alu_c;
        r_err <= w_alu_err;
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= w_mul_hi_nxt;
      r_lo  <= w_mul_lo_nxt;
      if (w_last_iter) begin
        r_res <= w_mul_lo_nxt;
        r_c   <= 1'b0;
        r_err <= |w_mul_hi_nxt;
      end
`ifdef SEQ_ALU_DIV_EN
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= w_div_rem_nxt;
      r_lo  <= w_div_quo_nxt;
      if (w_last_iter) begin
        r_res <= r_rem_sel ? w_div_rem_nxt : w_div_quo_nxt;
        r_c   <= 1'b0;
        r_err <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Scoreboard bench for seq_alu_unit at WIDTH=32: directed ops push expected results,
// a negedge monitor checks latency, held values under backpressure and final flags.
module tb_seq_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic        c;
  logic        n;
  logic        z;
  logic        err;

  seq_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .c(c), .n(n), .z(z), .err(err)
  );

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        err;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_cur;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: latency on first sight, held values while stalled, full check on transfer.
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: out_valid=1 r=%0h with no pending op", r);
      end else begin
        mon_cur = sb[0];
        if (!seen) begin
          chk({mon_cur.nm, "_lat"}, 64'(cyc - mon_cur.acc + 1), 64'(mon_cur.lat));
          seen = 1;
        end
        if (!out_ready) begin
          chk({mon_cur.nm, "_hold_r"}, 64'(r), 64'(mon_cur.r));
          chk({mon_cur.nm, "_hold_n"}, 64'(n), 64'(mon_cur.r[31]));
          chk({mon_cur.nm, "_hold_in_ready"}, 64'(in_ready), 64'(0));
        end else begin
          chk({mon_cur.nm, "_r"}, 64'(r), 64'(mon_cur.r));
          chk({mon_cur.nm, "_c"}, 64'(c), 64'(mon_cur.c));
          chk({mon_cur.nm, "_n"}, 64'(n), 64'(mon_cur.r[31]));
          chk({mon_cur.nm, "_z"}, 64'(z), 64'(mon_cur.r == 32'h0));
          chk({mon_cur.nm, "_err"}, 64'(err), 64'(mon_cur.err));
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [31:0] er, input logic ec, input logic ee,
                      input int lat, input string nm, output int waited);
    exp_t e;
    waited = 0;
    op = o; a = xa; b = xb; in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL %s_accept_timeout: in_ready=0 after %0d cycles, expected 1", nm, waited);
      in_valid = 1'b0;
      return;
    end
    e.r = er; e.c = ec; e.err = ee; e.lat = lat; e.acc = cyc + 1; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_r", 64'(r), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_c", 64'(c), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    send(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, "add_carry", w);
    drain();
    send(4'd1, 32'h0000_0FFF, 32'h0000_1000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, "sub_borrow", w);
    send(4'd0, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1, "add_b2b", w);
    chk("b2b_nobubble", 64'(w), 64'(0));
    send(4'd1, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1, "sub_equal", w);
    send(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1, "and", w);
    send(4'd3, 32'hA000_0000, 32'h0000_000B, 32'hA000_000B, 1'b0, 1'b0, 1, "or", w);
    send(4'd4, 32'h5555_AAAA, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0, 1, "xor_zero", w);
    send(4'd5, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1, "shl_31", w);
    send(4'd5, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 1, "shl_amt_wrap", w);
    send(4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1, "shr", w);
    send(4'd12, 32'h1234, 32'h1, 32'h0, 1'b0, 1'b1, 1, "illegal_12", w);
    send(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1, "illegal_15", w);
    drain();

    send(4'd8, 32'h1234, 32'h10, 32'h0001_2340, 1'b0, 1'b0, 33, "mul", w);
    send(4'd8, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b1, 33, "mul_ovf", w);
    send(4'd8, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b0, 33, "mul_ffff", w);
`ifdef SEQ_ALU_DIV_EN
    send(4'd9, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, "div", w);
    send(4'd10, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33, "rem", w);
`else
    send(4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 1, "div_disabled", w);
    send(4'd10, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 1, "rem_disabled", w);
`endif
    send(4'd9, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1, "div_by_zero", w);
    send(4'd10, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1, "rem_by_zero", w);
    drain();

    out_ready = 1'b0;
    send(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1, "sha_bp", w);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    drain();

    send(4'd8, 32'd3, 32'd3, 32'd9, 1'b0, 1'b0, 33, "mul_reset", w);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_rst_out_valid", 64'(out_valid), 64'(0));
    chk("midop_rst_r", 64'(r), 64'(0));
    chk("midop_rst_err", 64'(err), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midop_release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, "add_after_rst", w);
    drain();
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
